decoder_rr_arbiter: RTL



---
 rtl/decoder_rr_arbiter.sv | 79 +++++++
 1 files changed

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: 8-way round-robin arbiter driving a 3:8 decoder select/enable,
// with a hold timeout that revokes long grants and locks the offender out until it drops req.
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout,
    output logic [7:0] lock_mask
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_nxt;
    logic [2:0] ptr, ptr_nxt, idx_nxt, win;
    logic valid_nxt, to_nxt, found;
    logic [7:0] elig, lock_nxt;
    logic [CNT_W-1:0] hold_cnt, cnt_nxt;
    assign elig = req & ~lock_mask;
    always_comb begin
        win = ptr;
        found = 1'b0;
        for (int k = 0; k < 8; k++)
            if (!found && elig[ptr + 3'(k)]) begin
                win = ptr + 3'(k);
                found = 1'b1;
            end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            lock_mask <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= to_nxt;
            lock_mask <= lock_nxt;
            hold_cnt  <= cnt_nxt;
        end
    // Locks clear on any edge where the requester has let go; set only on a timeout.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = gnt_idx;
        valid_nxt = gnt_valid;
        to_nxt    = 1'b0;
        cnt_nxt   = hold_cnt;
        lock_nxt  = lock_mask & req;
        if (state == IDLE) begin
            if (found) begin
                idx_nxt   = win;
                valid_nxt = 1'b1;
                cnt_nxt   = CNT_W'(1);
                ptr_nxt   = win + 3'd1;
                state_nxt = GRANT;
            end
        end else if (!req[gnt_idx]) begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
        end else if (MAX_HOLD != 0 && hold_cnt == CNT_W'(MAX_HOLD)) begin
            valid_nxt = 1'b0;
            to_nxt    = 1'b1;
            lock_nxt  = lock_nxt | (8'd1 << gnt_idx);
            state_nxt = IDLE;
        end else
            cnt_nxt = (hold_cnt == '1) ? hold_cnt : hold_cnt + CNT_W'(1);
    end
    always_comb gnt = gnt_valid ? 8'd1 << gnt_idx : 8'd0;
endmodule
